// File: rtl/fifo_drain_packer.sv
// Drains the byte FIFO one entry per two cycles and packs bytes into WORD_BYTES-wide words.
// A byte already popped when reset asserts is lost; users must tolerate that on reset.
module fifo_drain_packer #(
  parameter int WORD_BYTES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              fifo_data,
  input  logic                    fifo_empty,
  output logic                    read_en,
  input  logic                    flush_req,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic [3:0]              out_count,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int            IW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_MAX   = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0]    LAST_LANE  = 4'(WORD_BYTES - 1);
  localparam logic [3:0]    FULL_CNT   = 4'(WORD_BYTES);
  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {FILL, WAIT, HOLD} state_t;

  state_t                  state, state_next;
  logic [3:0]              byte_cnt;
  logic [IW-1:0]           idle_cnt;
  logic [8*WORD_BYTES-1:0] lanes;
  logic                    has_bytes, timeout_hit;
  logic                    flush_go, capture, accept, idle_tick;

  assign has_bytes   = (byte_cnt != 4'd0);
  assign timeout_hit = TIMEOUT_EN && (idle_cnt == IDLE_MAX);
  assign out_data    = lanes;
  assign busy        = has_bytes || (state != FILL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  // Flush outranks a pending read; read_en is also held low while reset is asserted.
  always_comb begin
    state_next = state;
    read_en    = 1'b0;
    flush_go   = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    idle_tick  = 1'b0;
    case (state)
      FILL: begin
        if (has_bytes && (flush_req || timeout_hit)) begin
          flush_go   = 1'b1;
          state_next = HOLD;
        end else if (!fifo_empty && reset) begin
          read_en    = 1'b1;
          state_next = WAIT;
        end else begin
          idle_tick  = has_bytes;
        end
      end
      WAIT: begin
        capture    = 1'b1;
        state_next = (byte_cnt == LAST_LANE) ? HOLD : FILL;
      end
      HOLD: begin
        if (out_ready) begin
          accept     = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= 4'd0;
      idle_cnt  <= '0;
      lanes     <= '0;
      out_count <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      if (capture) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          if (byte_cnt == 4'(k)) lanes[8*k +: 8] <= fifo_data;
        end
        byte_cnt <= byte_cnt + 4'd1;
        idle_cnt <= '0;
        if (byte_cnt == LAST_LANE) begin
          out_valid <= 1'b1;
          out_count <= FULL_CNT;
        end
      end
      if (flush_go) begin
        out_valid <= 1'b1;
        out_count <= byte_cnt;
      end
      if (accept) begin
        out_valid <= 1'b0;
        out_count <= 4'd0;
        byte_cnt  <= 4'd0;
        idle_cnt  <= '0;
        lanes     <= '0;
      end
      if (idle_tick && TIMEOUT_EN && (idle_cnt != IDLE_MAX)) idle_cnt <= idle_cnt + IW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Bench for fifo_drain_packer: emulates the byte FIFO and checks packed words against the popped byte stream.
module tb_fifo_drain_packer;

  localparam int WB = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      fifo_data = 8'h00;
  logic            fifo_empty = 1'b1;
  logic            read_en;
  logic            flush_req = 1'b0;
  logic [8*WB-1:0] out_data;
  logic [3:0]      out_count;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            busy;

  int              tests_run = 0;
  int              tests_failed = 0;
  logic [7:0]      q[$];
  logic [7:0]      popped[$];
  logic [8*WB-1:0] w_data[$];
  int              w_count[$];
  int              w_cycle[$];
  int              rd_cycle[$];
  int              cyc = 0;
  int              underflows = 0;
  int              valid_cycles = 0;
  bit              force_empty = 1'b0;

  always #5 clk = ~clk;

  fifo_drain_packer #(.WORD_BYTES(WB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .read_en(read_en), .flush_req(flush_req), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t required below 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected word built straight from the popped byte stream: byte i in lane i, rest zero.
  function automatic logic [8*WB-1:0] pack_bytes(int start, int n);
    logic [8*WB-1:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = popped[start+i];
    return w;
  endfunction

  task automatic clear_logs();
    popped.delete(); w_data.delete(); w_count.delete(); w_cycle.delete(); rd_cycle.delete();
    underflows = 0; valid_cycles = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0; flush_req = 1'b0; out_ready = 1'b0; force_empty = 1'b0;
    q.delete(); fifo_empty = 1'b1; fifo_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  // One clock: sample the DUT before the edge, then behave as the FIFO (data one cycle after read_en).
  task automatic step();
    logic rd;
    #1;
    rd = read_en;
    if (rd && fifo_empty) underflows++;
    if (rd) rd_cycle.push_back(cyc);
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready) begin
      w_data.push_back(out_data);
      w_count.push_back(int'(out_count));
      w_cycle.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rd && q.size() > 0) begin
      fifo_data = q.pop_front();
      popped.push_back(fifo_data);
    end else begin
      fifo_data = 8'($urandom);
    end
    fifo_empty = force_empty || (q.size() == 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    fifo_empty = 1'b0; flush_req = 1'b1; out_ready = 1'b1; fifo_data = 8'hFF;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_count, out_data} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got valid=%b count=%0d data=%h required all zero", out_valid, out_count, out_data);
    end
    tests_run++;
    if ({read_en, busy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_read_busy: got read_en=%b busy=%b required 0 0", read_en, busy);
    end
    do_reset();
  endtask

  task automatic test_full_word();
    bit gaps_ok;
    do_reset();
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    fifo_empty = 1'b0; out_ready = 1'b1;
    repeat (14) step();
    tests_run++;
    if (rd_cycle.size() !== 4) begin
      tests_failed++;
      $display("[TB] FAIL full_reads: got %0d reads required 4", rd_cycle.size());
    end
    gaps_ok = (rd_cycle.size() == 4);
    for (int i = 0; i + 1 < rd_cycle.size(); i++) if (rd_cycle[i+1] - rd_cycle[i] != 2) gaps_ok = 1'b0;
    tests_run++;
    if (gaps_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL full_read_spacing: got non-alternating read pulses required one every 2 cycles");
    end
    tests_run++;
    if (w_data.size() !== 1 || valid_cycles !== 1) begin
      tests_failed++;
      $display("[TB] FAIL full_word_count: got %0d words, %0d valid cycles required 1 and 1", w_data.size(), valid_cycles);
    end
    if (w_data.size() > 0 && rd_cycle.size() == 4) begin
      tests_run++;
      if (w_data[0] !== 32'h44332211 || w_count[0] !== 4) begin
        tests_failed++;
        $display("[TB] FAIL full_word_data: got %h/%0d required 44332211/4", w_data[0], w_count[0]);
      end
      tests_run++;
      if (w_cycle[0] !== rd_cycle[3] + 2) begin
        tests_failed++;
        $display("[TB] FAIL full_latency: got valid at cycle %0d required %0d", w_cycle[0], rd_cycle[3] + 2);
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_busy_idle: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int reads_before;
    do_reset();
    for (int i = 0; i < 6; i++) q.push_back(8'(8'hA0 + i));
    fifo_empty = 1'b0; out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_first_valid: got out_valid=%b after %0d cycles required 1", out_valid, n);
    end
    reads_before = rd_cycle.size();
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if ({out_valid, out_count, out_data} !== {1'b1, 4'd4, 32'hA3A2A1A0}) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_stable: got valid=%b count=%0d data=%h required 1/4/a3a2a1a0", out_valid, out_count, out_data);
      end
      step();
    end
    tests_run++;
    if (rd_cycle.size() !== reads_before) begin
      tests_failed++;
      $display("[TB] FAIL bp_no_read_in_hold: got %0d reads required %0d", rd_cycle.size(), reads_before);
    end
    out_ready = 1'b1;
    step();
    repeat (6) step();
    tests_run++;
    if (w_data.size() !== 1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_partial_waits: got %0d words busy=%b required 1 word busy=1", w_data.size(), busy);
    end
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (3) step();
    tests_run++;
    if (w_data.size() !== 2) begin
      tests_failed++;
      $display("[TB] FAIL bp_word_count: got %0d words required 2", w_data.size());
    end else begin
      tests_run++;
      if (w_data[0] !== 32'hA3A2A1A0 || w_data[1] !== 32'h0000A5A4 || w_count[1] !== 2) begin
        tests_failed++;
        $display("[TB] FAIL bp_words: got %h, %h/%0d required a3a2a1a0, 0000a5a4/2", w_data[0], w_data[1], w_count[1]);
      end
    end
  endtask

  task automatic test_empty();
    do_reset();
    force_empty = 1'b1; fifo_empty = 1'b1;
    q = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 50; i++) begin
      flush_req = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    tests_run++;
    if (rd_cycle.size() !== 0 || valid_cycles !== 0 || underflows !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL empty_idle: got reads=%0d valid=%0d underflow=%0d busy=%b required 0 0 0 0",
               rd_cycle.size(), valid_cycles, underflows, busy);
    end
    force_empty = 1'b0; flush_req = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    q = '{8'h5A};
    fifo_empty = 1'b0; out_ready = 1'b1;
    n = 0;
    while (w_data.size() == 0 && n < 40) begin step(); n++; end
    tests_run++;
    if (w_data.size() !== 1 || rd_cycle.size() !== 1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_emit: got %0d words %0d reads required 1 and 1", w_data.size(), rd_cycle.size());
    end else begin
      tests_run++;
      if (w_data[0] !== 32'h0000005A || w_count[0] !== 1) begin
        tests_failed++;
        $display("[TB] FAIL timeout_word: got %h/%0d required 0000005a/1", w_data[0], w_count[0]);
      end
      tests_run++;
      if (w_cycle[0] !== rd_cycle[0] + 2 + TO) begin
        tests_failed++;
        $display("[TB] FAIL timeout_delay: got valid at cycle %0d required %0d", w_cycle[0], rd_cycle[0] + 2 + TO);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int n;
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    fifo_empty = 1'b0; out_ready = 1'b1;
    n = 0;
    while (rd_cycle.size() < 4 && n < 40) begin step(); n++; end
    tests_run++;
    if (rd_cycle.size() !== 4 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rw_reach_wait: got %0d reads busy=%b required 4 reads busy=1", rd_cycle.size(), busy);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_count, out_data} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rw_async_outputs: got valid=%b count=%0d data=%h required all zero", out_valid, out_count, out_data);
    end
    tests_run++;
    if ({read_en, busy} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL rw_async_read_busy: got read_en=%b busy=%b required 0 0", read_en, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (w_data.size() == 0 && n < 40) begin step(); n++; end
    tests_run++;
    if (w_data.size() !== 1) begin
      tests_failed++;
      $display("[TB] FAIL rw_fresh_count: got %0d words required 1", w_data.size());
    end else begin
      tests_run++;
      if (w_data[0] !== pack_bytes(4, 4) || w_count[0] !== 4) begin
        tests_failed++;
        $display("[TB] FAIL rw_fresh_word: got %h/%0d required %h/4", w_data[0], w_count[0], pack_bytes(4, 4));
      end
    end
  endtask

  task automatic test_flush_vs_read();
    int n;
    do_reset();
    q = '{8'($urandom), 8'($urandom)};
    fifo_empty = 1'b0; out_ready = 1'b1;
    n = 0;
    while (rd_cycle.size() < 2 && n < 20) begin step(); n++; end
    step();
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
    fifo_empty = 1'b0; flush_req = 1'b1;
    #1;
    tests_run++;
    if (read_en !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fr_flush_wins: got read_en=%b busy=%b required 0 1", read_en, busy);
    end
    step();
    flush_req = 1'b0;
    tests_run++;
    if ({out_valid, out_count, out_data} !== {1'b1, 4'd2, pack_bytes(0, 2)}) begin
      tests_failed++;
      $display("[TB] FAIL fr_partial: got valid=%b count=%0d data=%h required 1/2/%h", out_valid, out_count, out_data, pack_bytes(0, 2));
    end
    n = 0;
    while (w_data.size() < 2 && n < 40) begin step(); n++; end
    tests_run++;
    if (w_data.size() !== 2) begin
      tests_failed++;
      $display("[TB] FAIL fr_word_count: got %0d words required 2", w_data.size());
    end else begin
      tests_run++;
      if (w_data[1] !== pack_bytes(2, 4) || w_count[1] !== 4) begin
        tests_failed++;
        $display("[TB] FAIL fr_next_lane0: got %h/%0d required %h/4", w_data[1], w_count[1], pack_bytes(2, 4));
      end
    end
  endtask

  task automatic test_random();
    int              n;
    int              idx;
    bit              hold_pending;
    logic [8*WB-1:0] hold_data;
    logic [3:0]      hold_count;
    do_reset();
    hold_pending = 1'b0; hold_data = '0; hold_count = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if (hold_pending) begin
        tests_run++;
        if ({out_valid, out_count, out_data} !== {1'b1, hold_count, hold_data}) begin
          tests_failed++;
          $display("[TB] FAIL rand_hold_stable: got valid=%b count=%0d data=%h required 1/%0d/%h",
                   out_valid, out_count, out_data, hold_count, hold_data);
        end
      end
      if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom));
      fifo_empty = (q.size() == 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush_req  = ($urandom_range(0, 15) == 0);
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_count   = out_count;
      step();
    end
    flush_req = 1'b1; out_ready = 1'b1;
    n = 0;
    while ((q.size() > 0 || busy) && n < 300) begin step(); n++; end
    flush_req = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rand_drain: got busy=%b fifo_left=%0d required 0 0", busy, q.size());
    end
    idx = 0;
    for (int j = 0; j < w_data.size(); j++) begin
      tests_run++;
      if ((w_count[j] >= 1 && w_count[j] <= WB) !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL rand_count_range: got count %0d in word %0d required 1..%0d", w_count[j], j, WB);
      end else begin
        tests_run++;
        if (w_data[j] !== pack_bytes(idx, w_count[j])) begin
          tests_failed++;
          $display("[TB] FAIL rand_word: got %h in word %0d required %h", w_data[j], j, pack_bytes(idx, w_count[j]));
        end
        idx += w_count[j];
      end
    end
    tests_run++;
    if (idx !== popped.size() || underflows !== 0) begin
      tests_failed++;
      $display("[TB] FAIL rand_stream: got %0d bytes out of %0d popped, %0d underflows required equal and 0",
               idx, popped.size(), underflows);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_backpressure();
    test_empty();
    test_timeout();
    test_reset_in_wait();
    test_flush_vs_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_drain_packer.md
Name: fifo_drain_packer

Overview:
- Downstream consumer of the byte FIFO top: drains 8-bit entries on the read side (drives read_en, samples data_out, honours underflow) and packs them into WORD_BYTES-wide words for processor 2.
- Packed words are presented over a valid/ready handshake.
- Partial words are emitted on an explicit flush or after an idle timeout, so a trickle of bytes never stalls.

Parameters:
WORD_BYTES, 4, bytes per output word (2..8)
TIMEOUT, 16, idle cycles with a partial word before auto-flush; 0 disables auto-flush

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fifo_data  input  8  FIFO data_out; valid exactly 1 cycle after read_en is asserted
fifo_empty  input  1  FIFO underflow/empty flag; high = no entry available
read_en  output  1  FIFO pop request, 1-cycle pulse
flush_req  input  1  level request to emit the current partial word
out_data  output  8*WORD_BYTES  packed word; byte k in bits [8k+7:8k], first byte read in byte 0
out_count  output  4  number of valid bytes in out_data (1..WORD_BYTES)
out_valid  output  1  out_data/out_count valid
out_ready  input  1  consumer accepts the word when out_valid && out_ready
busy  output  1  high when the byte count is nonzero or the state is not FILL

Behaviour:
- Reset, reset=0, asynchronous:
  - state=FILL; byte_cnt=0; idle_cnt=0.
  - out_data=0, out_count=0, out_valid=0, read_en=0, busy=0.
  - Any partial word is discarded.
  - A byte popped in the cycle reset asserts is lost. This is accepted and must be documented to users.
- States: FILL, WAIT, HOLD.
- FILL:
  - Flush priority: if byte_cnt>0 and (flush_req or idle_cnt==TIMEOUT-1 with TIMEOUT!=0), go to HOLD with out_count=byte_cnt; no read is issued that cycle.
  - Otherwise, if fifo_empty=0, read_en=1 (combinational decode of state and inputs) and go to WAIT.
  - Otherwise stay in FILL.
  - read_en is never asserted while fifo_empty=1, so the packer never causes FIFO underflow.
- WAIT (exactly 1 cycle):
  - Capture fifo_data into byte lane byte_cnt; byte_cnt+=1; idle_cnt=0.
  - If the new byte_cnt==WORD_BYTES, go to HOLD with out_count=WORD_BYTES; else return to FILL.
  - read_en=0 in WAIT: at most one read is outstanding, so peak throughput is 1 byte per 2 cycles.
- HOLD:
  - out_valid=1; out_data and out_count stay stable until accepted.
  - On out_ready=1: out_valid drops the next cycle; byte_cnt=0; idle_cnt=0; lanes cleared to 0; go to FILL.
  - out_ready is ignored outside HOLD. flush_req is ignored in HOLD.
- idle_cnt:
  - Increments in FILL when byte_cnt>0 and no read is issued.
  - Saturates at TIMEOUT-1.
  - Held at 0 when byte_cnt==0.
- Flush with byte_cnt==0 is ignored; no empty words are ever emitted.
- Unfilled lanes of a partial word read as 0.
- Latency: the last byte's read_en at cycle t gives out_valid=1 at cycle t+2.
- fifo_empty toggling during WAIT has no effect, because the pop has already been committed.
- out_data, out_count and out_valid are registered outputs.

Test Plan:
1. Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> read_en pulses on 4 alternate cycles; out_data=0x44332211, out_count=4, out_valid high for 1 cycle; busy returns to 0.
2. 6 bytes 0xA0..0xA5, out_ready held 0 for 10 cycles after the first word -> word 0xA3A2A1A0 held stable with no read_en during HOLD; after ready, second partial waits, flush_req pulse -> out_data=0x0000A5A4, out_count=2.
3. FIFO empty (fifo_empty=1) for 50 cycles after reset, flush_req toggling -> read_en never asserted, out_valid never asserted.
4. TIMEOUT=16, single byte 0x5A then fifo_empty=1 -> out_valid rises 16 cycles after the byte capture with out_data=0x0000005A, out_count=1.
5. Reset asserted in WAIT after 3 bytes captured -> all outputs 0 immediately (asynchronously); the next 4 bytes form a fresh word starting at lane 0.
6. flush_req and fifo_empty=0 in the same FILL cycle with byte_cnt=2 -> no read_en that cycle; partial word emitted with out_count=2; the next byte lands in lane 0 of the next word.
